// File: rtl/uart_tx_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_rd
// Purpose  : UART transmitter popping words from a FWFT async-FIFO read port,
//            one line bit per CLK, optional parity, back-to-back frames.
//            Optional macro UART_TX_STOP2_EN selects two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_rd #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  F_EMPTY,
    input  logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_INC,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int            CW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_cnt, w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_par, w_par_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_rd_inc, w_rd_inc_nxt;
    logic                  w_capture;
    logic                  w_last_stop;
`ifdef UART_TX_STOP2_EN
    logic                  r_stop2, w_stop2_nxt;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_rd_inc <= 1'b0;
`ifdef UART_TX_STOP2_EN
            r_stop2  <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shift  <= w_shift_nxt;
            r_par_en <= w_par_en_nxt;
            r_par    <= w_par_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_rd_inc <= w_rd_inc_nxt;
`ifdef UART_TX_STOP2_EN
            r_stop2  <= w_stop2_nxt;
`endif
        end
    end

    // Registered outputs lead the state: the value set on entering a state
    // is the bit on the line for the whole of that state.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shift_nxt  = r_shift;
        w_par_en_nxt = r_par_en;
        w_par_nxt    = r_par;
        w_tx_nxt     = r_tx;
        w_busy_nxt   = r_busy;
        w_rd_inc_nxt = 1'b0;
        w_capture    = 1'b0;
        w_last_stop  = 1'b0;
`ifdef UART_TX_STOP2_EN
        w_stop2_nxt  = r_stop2;
`endif

        case (r_state)
            S_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_busy_nxt = 1'b0;
                w_capture  = ~F_EMPTY;
            end
            S_START: begin
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                w_cnt_nxt   = '0;
                w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    if (r_par_en) begin
                        w_tx_nxt    = r_par;
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_state_nxt = S_STOP;
                    end
                end else begin
                    w_tx_nxt    = r_shift[0];
                    w_shift_nxt = r_shift >> 1;
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                w_tx_nxt    = 1'b1;
                w_state_nxt = S_STOP;
            end
            S_STOP: begin
`ifdef UART_TX_STOP2_EN
                w_stop2_nxt = ~r_stop2;
                w_last_stop = r_stop2;
`else
                w_last_stop = 1'b1;
`endif
                if (w_last_stop) begin
                    if (!F_EMPTY) begin
                        w_capture = 1'b1;
                    end else begin
                        w_tx_nxt    = 1'b1;
                        w_busy_nxt  = 1'b0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nxt    = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase

        // Shared by IDLE and the end of STOP so back-to-back frames have no gap.
        if (w_capture) begin
            w_shift_nxt  = RD_DATA;
            w_par_en_nxt = PAR_EN;
            w_par_nxt    = (^RD_DATA) ^ PAR_TYP;
            w_rd_inc_nxt = 1'b1;
            w_tx_nxt     = 1'b0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = S_START;
        end
    end

    assign RD_INC = r_rd_inc;
    assign TX_OUT = r_tx;
    assign BUSY   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_rd.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_rd
// Purpose  : Scoreboard bench for uart_tx_fifo_rd with a behavioural FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_rd;

    logic       CLK = 1'b0;
    logic       RST;
    logic       F_EMPTY;
    logic [7:0] RD_DATA;
    logic       RD_INC;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       TX_OUT;
    logic       BUSY;

    uart_tx_fifo_rd #(.DATA_WIDTH(8)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .F_EMPTY (F_EMPTY),
        .RD_DATA (RD_DATA),
        .RD_INC  (RD_INC),
        .PAR_EN  (PAR_EN),
        .PAR_TYP (PAR_TYP),
        .TX_OUT  (TX_OUT),
        .BUSY    (BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] bits;
        int          len;
        bit          idle_after;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] fq[$];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en  = 1'b0;
    bit         mon_act = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fifo_sync();
        F_EMPTY = (fq.size() == 0);
        RD_DATA = (fq.size() != 0) ? fq[0] : 8'h00;
    endtask

    // Line order, index 0 first: start, d0..d7, [parity], stop(s).
    function automatic exp_t mk(input logic [7:0] d, input bit pe, input bit pt, input bit ia);
        exp_t e;
        int   n;
        e.bits = '0;
        e.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) e.bits[1+i] = d[i];
        n = 9;
        if (pe) begin
            e.bits[n] = (^d) ^ pt;
            n++;
        end
        e.bits[n] = 1'b1;
        n++;
`ifdef UART_TX_STOP2_EN
        e.bits[n] = 1'b1;
        n++;
`endif
        e.len = n;
        e.idle_after = ia;
        return e;
    endfunction

    task automatic push_word(input logic [7:0] d, input bit pe, input bit pt, input bit ia);
        fq.push_back(d);
        sb.push_back(mk(d, pe, pt, ia));
        fifo_sync();
    endtask

    // FWFT FIFO pops on the read-increment pulse.
    always @(negedge CLK) begin
        if (RD_INC && fq.size() != 0) begin
            void'(fq.pop_front());
            fifo_sync();
        end
    end

    task automatic run_frames();
        exp_t       e;
        logic [11:0] got;
        bit         busy_ok, inc_ok, more;
        more = 1'b1;
        while (more) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 32'd1, 32'd0);
                e = mk(8'h00, 1'b0, 1'b0, 1'b1);
            end else begin
                e = sb.pop_front();
            end
            got = '0;
            busy_ok = 1'b1;
            inc_ok  = 1'b1;
            for (int i = 0; i < e.len; i++) begin
                if (i > 0) @(negedge CLK);
                got[i] = TX_OUT;
                if (BUSY !== 1'b1) busy_ok = 1'b0;
                if (RD_INC !== (i == 0)) inc_ok = 1'b0;
            end
            chk("frame_bits", {20'd0, got}, {20'd0, e.bits});
            chk("frame_busy", {31'd0, busy_ok}, 32'd1);
            chk("frame_rd_inc", {31'd0, inc_ok}, 32'd1);
            @(negedge CLK);
            if (e.idle_after) begin
                chk("idle_after", {29'd0, BUSY, TX_OUT, RD_INC}, {29'd0, 3'b010});
                more = 1'b0;
            end else begin
                chk("back_to_back", {29'd0, BUSY, TX_OUT, RD_INC}, {29'd0, 3'b101});
                more = (RD_INC === 1'b1);
            end
        end
    endtask

    always begin
        @(negedge CLK);
        if (mon_en && !RST) begin
            if (RD_INC === 1'b1) begin
                mon_act = 1'b1;
                run_frames();
                mon_act = 1'b0;
            end else if (BUSY !== 1'b0) begin
                chk("busy_unexpected", {31'd0, BUSY}, 32'd0);
            end
        end
    end

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !mon_act && fq.size() == 0) done = 1'b1;
        end
        if (!done) chk("wait_done_timeout", 32'd1, 32'd0);
        @(negedge CLK);
    endtask

    task automatic wait_rd_inc();
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge CLK);
            if (RD_INC === 1'b1) seen = 1'b1;
        end
        if (!seen) chk("rd_inc_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        // Reset with a non-empty FIFO: nothing may be popped.
        RST     = 1'b1;
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        fq.push_back(8'hFF);
        fifo_sync();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("reset_outputs", {29'd0, BUSY, TX_OUT, RD_INC}, {29'd0, 3'b010});
        end
        chk("reset_no_pop", fq.size(), 32'd1);
        fq.delete();
        fifo_sync();
        RST = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;

        // Single word, no parity.
        push_word(8'hA5, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Parity even then odd.
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        push_word(8'h03, 1'b1, 1'b0, 1'b1);
        wait_done();
        PAR_TYP = 1'b1;
        push_word(8'h03, 1'b1, 1'b1, 1'b1);
        wait_done();

        // Back-to-back frames.
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b0;
        push_word(8'h55, 1'b0, 1'b0, 1'b0);
        push_word(8'hFF, 1'b0, 1'b0, 1'b1);
        wait_done();

        // Parity enable dropped during data bit 3 of the first frame.
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        push_word(8'h0F, 1'b1, 1'b0, 1'b0);
        push_word(8'h3C, 1'b0, 1'b0, 1'b1);
        wait_rd_inc();
        repeat (4) @(negedge CLK);
        PAR_EN = 1'b0;
        wait_done();

        // Reset during data bit 4 of 0xA5.
        mon_en = 1'b0;
        fq.push_back(8'hA5);
        fifo_sync();
        wait_rd_inc();
        repeat (5) @(negedge CLK);
        chk("abort_data_bit4", {31'd0, TX_OUT}, 32'd0);
        chk("abort_busy_before", {31'd0, BUSY}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("abort_async", {29'd0, BUSY, TX_OUT, RD_INC}, {29'd0, 3'b010});
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("abort_word_lost", fq.size(), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            chk("post_reset_idle", {29'd0, BUSY, TX_OUT, RD_INC}, {29'd0, 3'b010});
        end

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
